// File: rtl/line_draw_sequencer_if.sv
// Engine handshake and framebuffer write bus for line_draw_sequencer.
//  master: the sequencer. It drives the engine command (start/abort, endpoints, colour)
//          and the framebuffer write port. It receives done and the engine pixel writes.
//  slave : the line engine / framebuffer side, with the opposite directions.
//  eng_addr and fb_addr are packed {y,x}.
interface line_draw_sequencer_if #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 8
);
    logic             eng_start;
    logic             eng_abort;
    logic [XW-1:0]    eng_x0;
    logic [XW-1:0]    eng_x1;
    logic [YW-1:0]    eng_y0;
    logic [YW-1:0]    eng_y1;
    logic [CW-1:0]    eng_color;
    logic             eng_done;
    logic             eng_we;
    logic [XW+YW-1:0] eng_addr;
    logic             fb_we;
    logic [XW+YW-1:0] fb_addr;
    logic [CW-1:0]    fb_data;

    modport master (
        output eng_start, eng_abort, eng_x0, eng_x1, eng_y0, eng_y1, eng_color,
        output fb_we, fb_addr, fb_data,
        input  eng_done, eng_we, eng_addr
    );

    modport slave (
        input  eng_start, eng_abort, eng_x0, eng_x1, eng_y0, eng_y1, eng_color,
        input  fb_we, fb_addr, fb_data,
        output eng_done, eng_we, eng_addr
    );
endinterface

// File: rtl/line_draw_sequencer.sv
// Frame-level controller for the line-drawing datapath.
// A redraw request waits for a frame boundary, then clears the framebuffer and walks
// the line table. Each valid segment is handed to the Bresenham engine. The sequencer
// owns the framebuffer write port and grants it to the clear sweep or to the engine.
// Ports:
//  clk, rst               clock, asynchronous active-high reset
//  redraw, abort          single-cycle requests
//  vsync_edge             single-cycle frame-boundary strobe
//  tbl_idx / tbl_*        line table read port (1-cycle read latency)
//  bus (master)           engine start/abort/endpoints/done plus framebuffer write port
//  busy                   high in every state except IDLE
//  frame_done             one-cycle pulse when the table walk completes
//  lines_drawn            number of segments completed in the current frame
module line_draw_sequencer #(
    parameter int XW        = 8,
    parameter int YW        = 7,
    parameter int NUM_LINES = 16,
    parameter int IDXW      = 4,
    parameter int CW        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redraw,
    input  logic                  abort,
    input  logic                  vsync_edge,
    output logic [IDXW-1:0]       tbl_idx,
    input  logic                  tbl_valid,
    input  logic [XW-1:0]         tbl_x0,
    input  logic [XW-1:0]         tbl_x1,
    input  logic [YW-1:0]         tbl_y0,
    input  logic [YW-1:0]         tbl_y1,
    input  logic [CW-1:0]         tbl_color,
    line_draw_sequencer_if.master bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic [IDXW:0]         lines_drawn
);
    localparam int AW = XW + YW;

    typedef enum logic [2:0] {
        IDLE, WAIT_VS, CLEAR, FETCH, ISSUE, WAIT_ENG, NEXT, DONE
    } state_t;

    state_t          state_reg;
    logic            pending_reg;
    logic [IDXW-1:0] idx_reg;
    logic [AW-1:0]   clr_cnt_reg;
    logic [IDXW:0]   lines_drawn_reg;
    logic            eng_start_reg;
    logic            eng_abort_reg;
    logic [XW-1:0]   eng_x0_reg;
    logic [XW-1:0]   eng_x1_reg;
    logic [YW-1:0]   eng_y0_reg;
    logic [YW-1:0]   eng_y1_reg;
    logic [CW-1:0]   eng_color_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            pending_reg     <= 1'b0;
            idx_reg         <= '0;
            clr_cnt_reg     <= '0;
            lines_drawn_reg <= '0;
            eng_start_reg   <= 1'b0;
            eng_abort_reg   <= 1'b0;
            eng_x0_reg      <= '0;
            eng_x1_reg      <= '0;
            eng_y0_reg      <= '0;
            eng_y1_reg      <= '0;
            eng_color_reg   <= '0;
        end else begin
            eng_start_reg <= 1'b0;
            eng_abort_reg <= 1'b0;
            if (abort && state_reg != IDLE) begin
                // Abort overrides everything, including a same-cycle redraw.
                state_reg     <= IDLE;
                pending_reg   <= 1'b0;
                eng_abort_reg <= (state_reg == WAIT_ENG);
            end else begin
                // One request can be queued while a frame is in progress (DONE included).
                if (redraw && state_reg != IDLE)
                    pending_reg <= 1'b1;
                case (state_reg)
                    IDLE: begin
                        if ((redraw && !abort) || pending_reg) begin
                            state_reg       <= WAIT_VS;
                            pending_reg     <= 1'b0;
                            lines_drawn_reg <= '0;
                        end
                    end
                    WAIT_VS: begin
                        if (vsync_edge) begin
                            state_reg   <= CLEAR;
                            clr_cnt_reg <= '0;
                        end
                    end
                    CLEAR: begin
                        clr_cnt_reg <= clr_cnt_reg + AW'(1);
                        if (&clr_cnt_reg) begin
                            state_reg <= FETCH;
                            idx_reg   <= '0;
                        end
                    end
                    FETCH: state_reg <= ISSUE;  // table data arrives next cycle
                    ISSUE: begin
                        if (tbl_valid) begin
                            eng_x0_reg    <= tbl_x0;
                            eng_x1_reg    <= tbl_x1;
                            eng_y0_reg    <= tbl_y0;
                            eng_y1_reg    <= tbl_y1;
                            eng_color_reg <= tbl_color;
                            eng_start_reg <= 1'b1;
                            state_reg     <= WAIT_ENG;
                        end else begin
                            state_reg <= NEXT;
                        end
                    end
                    WAIT_ENG: begin
                        if (bus.eng_done) begin
                            lines_drawn_reg <= lines_drawn_reg + (IDXW+1)'(1);
                            state_reg       <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (idx_reg == IDXW'(NUM_LINES - 1)) begin
                            state_reg <= DONE;
                        end else begin
                            idx_reg   <= idx_reg + IDXW'(1);
                            state_reg <= FETCH;
                        end
                    end
                    DONE:    state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Framebuffer write port grant. An abort blanks the port in the very cycle it
    // arrives, so no stray pixel lands after the frame was cancelled.
    always_comb begin
        bus.fb_we   = 1'b0;
        bus.fb_addr = '0;
        bus.fb_data = '0;
        if (!abort) begin
            case (state_reg)
                CLEAR: begin
                    bus.fb_we   = 1'b1;
                    bus.fb_addr = clr_cnt_reg;
                end
                WAIT_ENG: begin
                    bus.fb_we   = bus.eng_we;
                    bus.fb_addr = bus.eng_addr;
                    bus.fb_data = eng_color_reg;
                end
                default: ;
            endcase
        end
    end

    assign bus.eng_start = eng_start_reg;
    assign bus.eng_abort = eng_abort_reg;
    assign bus.eng_x0    = eng_x0_reg;
    assign bus.eng_x1    = eng_x1_reg;
    assign bus.eng_y0    = eng_y0_reg;
    assign bus.eng_y1    = eng_y1_reg;
    assign bus.eng_color = eng_color_reg;

    assign tbl_idx     = idx_reg;
    assign busy        = (state_reg != IDLE);
    assign frame_done  = (state_reg == DONE);
    assign lines_drawn = lines_drawn_reg;
endmodule
